// File: rtl/time_hex_display.sv
// Purpose : selects running time or alarm setting, converts each binary field to BCD
//           (shift-add-3) and drives six active-low 7-segment digits, blinking while alarm=1.
// Latency : 29 rising edges from the sampling edge to the HEX change; busy high for 28 cycles.
// Backpressure: none; inputs that change mid-conversion are picked up in IDLE after UPDATE.
//
// Ports:
//   clk, reset (async, active-low)
//   sec/min/hr, secA/minA/hrA : binary time fields (8 bits each)
//   show_alarm : 1 = display alarm triple, 0 = running time
//   alarm      : alarm sounding, enables whole-display blink
//   busy       : conversion in progress
//   HEX0..HEX5 : sec ones/tens, min ones/tens, hr ones/tens (bit0=a .. bit6=g, active-low)
module time_hex_display #(
  parameter int BLINK_DIV = 25_000_000
) (
  input  logic       clk,
  input  logic       reset,
  input  logic [7:0] sec,
  input  logic [7:0] min,
  input  logic [7:0] hr,
  input  logic [7:0] secA,
  input  logic [7:0] minA,
  input  logic [7:0] hrA,
  input  logic       show_alarm,
  input  logic       alarm,
  output logic       busy,
  output logic [6:0] HEX0,
  output logic [6:0] HEX1,
  output logic [6:0] HEX2,
  output logic [6:0] HEX3,
  output logic [6:0] HEX4,
  output logic [6:0] HEX5
);

  localparam logic [6:0] SEG_ZERO  = 7'b1000000;
  localparam logic [6:0] SEG_DASH  = 7'b0111111;
  localparam logic [6:0] SEG_BLANK = 7'b1111111;
  localparam int CW = (BLINK_DIV > 1) ? $clog2(BLINK_DIV) : 1;

  typedef enum logic [1:0] {IDLE, SHIFT, STORE, UPDATE} state_t;

  state_t           state_q, state_d;
  logic [23:0]      sel_triple;   // {hr, min, sec} of the selected source
  logic [23:0]      snap_q;
  logic [23:0]      last_q;
  logic [1:0]       field_q;      // 0 = sec, 1 = min, 2 = hr
  logic [2:0]       iter_q;
  logic [15:0]      shreg_q;      // {tens, ones, bin}; hundreds are never displayed
  logic [15:0]      shift_d;
  logic [3:0]       adj_ones, adj_tens;
  logic [7:0]       cur_val, nxt_val;
  logic [5:0][6:0]  pend_q;
  logic [5:0][6:0]  disp_q;
  logic [CW-1:0]    blink_cnt_q;
  logic             blank_q;      // 1 = off phase of the blink

  function automatic logic [6:0] seg7(input logic [3:0] d);
    case (d)
      4'd0:    seg7 = 7'b1000000;
      4'd1:    seg7 = 7'b1111001;
      4'd2:    seg7 = 7'b0100100;
      4'd3:    seg7 = 7'b0110000;
      4'd4:    seg7 = 7'b0011001;
      4'd5:    seg7 = 7'b0010010;
      4'd6:    seg7 = 7'b0000010;
      4'd7:    seg7 = 7'b1111000;
      4'd8:    seg7 = 7'b0000000;
      4'd9:    seg7 = 7'b0010000;
      default: seg7 = SEG_BLANK;
    endcase
  endfunction

  assign sel_triple = show_alarm ? {hrA, minA, secA} : {hr, min, sec};

  always_comb begin
    cur_val = snap_q[7:0];
    nxt_val = 8'd0;
    case (field_q)
      2'd0: begin cur_val = snap_q[7:0];   nxt_val = snap_q[15:8];  end
      2'd1: begin cur_val = snap_q[15:8];  nxt_val = snap_q[23:16]; end
      2'd2: begin cur_val = snap_q[23:16]; nxt_val = 8'd0;          end
      default: begin cur_val = 8'd0;       nxt_val = 8'd0;          end
    endcase
  end

  // Shift-add-3 step; the hundreds digit falls off the top, values >99 show dashes anyway.
  always_comb begin
    adj_ones = shreg_q[11:8];
    adj_tens = shreg_q[15:12];
    if (shreg_q[11:8]  >= 4'd5) adj_ones = shreg_q[11:8]  + 4'd3;
    if (shreg_q[15:12] >= 4'd5) adj_tens = shreg_q[15:12] + 4'd3;
    shift_d = {adj_tens, adj_ones, shreg_q[7:0]} << 1;
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) state_q <= IDLE;
    else        state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (sel_triple != last_q) state_d = SHIFT;
      SHIFT:   if (iter_q == 3'd7)       state_d = STORE;
      STORE:   state_d = (field_q == 2'd2) ? UPDATE : SHIFT;
      UPDATE:  state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      snap_q  <= '0;
      last_q  <= '0;
      field_q <= '0;
      iter_q  <= '0;
      shreg_q <= '0;
      busy    <= 1'b0;
      pend_q  <= {6{SEG_ZERO}};
      disp_q  <= {6{SEG_ZERO}};
    end else begin
      case (state_q)
        IDLE: begin
          if (sel_triple != last_q) begin
            snap_q  <= sel_triple;
            last_q  <= sel_triple;
            field_q <= 2'd0;
            iter_q  <= 3'd0;
            shreg_q <= {8'd0, sel_triple[7:0]};
            busy    <= 1'b1;
          end
        end
        SHIFT: begin
          shreg_q <= shift_d;
          iter_q  <= iter_q + 3'd1;   // wraps to 0, ready for the next field
        end
        STORE: begin
          if (cur_val > 8'd99) begin
            pend_q[{field_q, 1'b1}] <= SEG_DASH;
            pend_q[{field_q, 1'b0}] <= SEG_DASH;
          end else begin
            pend_q[{field_q, 1'b1}] <= seg7(shreg_q[15:12]);
            pend_q[{field_q, 1'b0}] <= seg7(shreg_q[11:8]);
          end
          field_q <= field_q + 2'd1;
          shreg_q <= {8'd0, nxt_val};
        end
        UPDATE: begin
          disp_q <= pend_q;
          busy   <= 1'b0;
        end
        default: ;
      endcase
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      blink_cnt_q <= '0;
      blank_q     <= 1'b0;
    end else if (alarm) begin
      if (blink_cnt_q == CW'(BLINK_DIV - 1)) begin
        blink_cnt_q <= '0;
        blank_q     <= ~blank_q;
      end else begin
        blink_cnt_q <= blink_cnt_q + CW'(1);
      end
    end else begin
      blink_cnt_q <= '0;
      blank_q     <= 1'b0;
    end
  end

  assign HEX0 = blank_q ? SEG_BLANK : disp_q[0];
  assign HEX1 = blank_q ? SEG_BLANK : disp_q[1];
  assign HEX2 = blank_q ? SEG_BLANK : disp_q[2];
  assign HEX3 = blank_q ? SEG_BLANK : disp_q[3];
  assign HEX4 = blank_q ? SEG_BLANK : disp_q[4];
  assign HEX5 = blank_q ? SEG_BLANK : disp_q[5];

endmodule

// File: tb/tb_time_hex_display.sv
// Purpose : scoreboard bench for time_hex_display with directed vectors.
// Latency : expected HEX words are queued at stimulus time, popped on each busy fall.
// Backpressure: none; the stimulus waits fixed cycle budgets between vectors.
module tb_time_hex_display;

  logic       clk = 1'b0;
  logic       reset;
  logic [7:0] sec, min, hr, secA, minA, hrA;
  logic       show_alarm, alarm;
  logic       busy;
  logic [6:0] HEX0, HEX1, HEX2, HEX3, HEX4, HEX5;

  always #5 clk = ~clk;

  time_hex_display #(.BLINK_DIV(4)) dut (
    .clk(clk), .reset(reset),
    .sec(sec), .min(min), .hr(hr),
    .secA(secA), .minA(minA), .hrA(hrA),
    .show_alarm(show_alarm), .alarm(alarm),
    .busy(busy),
    .HEX0(HEX0), .HEX1(HEX1), .HEX2(HEX2), .HEX3(HEX3), .HEX4(HEX4), .HEX5(HEX5)
  );

  localparam logic [6:0] S_DASH  = 7'b0111111;
  localparam logic [6:0] S_BLANK = 7'b1111111;

  int          total = 0;
  int          bad   = 0;
  logic [41:0] expq[$];
  logic [41:0] hex_all;
  logic [41:0] blank_all;
  logic        busy_prev = 1'b0;
  int          busy_len  = 0;

  assign hex_all   = {HEX5, HEX4, HEX3, HEX2, HEX1, HEX0};
  assign blank_all = {6{S_BLANK}};

  // 10 stands for a dash
  function automatic logic [6:0] seg(input int d);
    case (d)
      0: seg = 7'b1000000;
      1: seg = 7'b1111001;
      2: seg = 7'b0100100;
      3: seg = 7'b0110000;
      4: seg = 7'b0011001;
      5: seg = 7'b0010010;
      6: seg = 7'b0000010;
      7: seg = 7'b1111000;
      8: seg = 7'b0000000;
      9: seg = 7'b0010000;
      default: seg = S_DASH;
    endcase
  endfunction

  function automatic logic [41:0] disp(input int h10, input int h1, input int m10,
                                       input int m1, input int s10, input int s1);
    return {seg(h10), seg(h1), seg(m10), seg(m1), seg(s10), seg(s1)};
  endfunction

  task automatic check(input string name, input logic [41:0] act, input logic [41:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Monitor: every busy fall is one completed UPDATE.
  always @(negedge clk) begin
    if (reset !== 1'b1) begin
      busy_prev = 1'b0;
      busy_len  = 0;
    end else begin
      if (busy === 1'b1) busy_len++;
      if (busy_prev === 1'b1 && busy === 1'b0) begin
        check("busy_len", 42'(busy_len), 42'd28);
        if (expq.size() == 0) check("unexpected_update", 42'd1, 42'd0);
        else                  check("update_hex", hex_all, expq.pop_front());
        busy_len = 0;
      end
      busy_prev = busy;
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, got timeout expected finish");
    $fatal(1);
  end

  initial begin
    int lat;
    logic [41:0] z0;
    logic [41:0] base;
    z0 = disp(0, 0, 0, 0, 0, 0);
    reset = 1'b0;
    sec = 0; min = 0; hr = 0; secA = 0; minA = 0; hrA = 0;
    show_alarm = 1'b0; alarm = 1'b0;

    // 1: reset state and quiet idle
    repeat (3) @(posedge clk);
    #1;
    check("reset_hex", hex_all, z0);
    check("reset_busy", 42'(busy), 42'd0);
    reset = 1'b1;
    for (int i = 0; i < 50; i++) begin
      @(posedge clk); #1;
      check("idle_hex", hex_all, z0);
      check("idle_busy", 42'(busy), 42'd0);
    end

    // 2: running time 07:22:45, with edge-accurate latency
    sec = 8'd45; min = 8'd22; hr = 8'd7;
    expq.push_back(disp(0, 7, 2, 2, 4, 5));
    lat = 0;
    for (int k = 1; k <= 40; k++) begin
      @(posedge clk); #1;
      if (lat == 0 && hex_all !== z0) lat = k;
    end
    check("latency", 42'(lat), 42'd29);

    // 3: switch to alarm view 07:21:00
    secA = 8'd0; minA = 8'd21; hrA = 8'd7; show_alarm = 1'b1;
    expq.push_back(disp(0, 7, 2, 1, 0, 0));
    repeat (35) @(posedge clk);
    #1;

    // 4: minutes out of range -> dashes
    show_alarm = 1'b0; min = 8'd150;
    expq.push_back(disp(0, 7, 10, 10, 4, 5));
    repeat (35) @(posedge clk);
    #1;

    // 5: blink with BLINK_DIV=4, then stop in the off phase
    base = disp(0, 7, 10, 10, 4, 5);
    alarm = 1'b1;
    for (int k = 1; k <= 13; k++) begin
      @(posedge clk); #1;
      check("blink", hex_all, (((k / 4) % 2) == 1) ? blank_all : base);
    end
    alarm = 1'b0;
    for (int k = 1; k <= 6; k++) begin
      @(posedge clk); #1;
      check("blink_stop", hex_all, base);
    end

    // 6a: input change at cycle 10 of a conversion
    min = 8'd22;
    expq.push_back(disp(0, 7, 2, 2, 4, 5));
    repeat (10) @(posedge clk);
    #1;
    sec = 8'd46;
    expq.push_back(disp(0, 7, 2, 2, 4, 6));
    repeat (19) @(posedge clk);
    #1;
    check("first_update_busy", 42'(busy), 42'd0);
    check("first_update_hex", hex_all, disp(0, 7, 2, 2, 4, 5));
    @(posedge clk); #1;
    check("reassert_busy", 42'(busy), 42'd1);
    repeat (35) @(posedge clk);
    #1;

    // 6b: reset at cycle 5 of a conversion, then resample after release
    sec = 8'd12;
    repeat (5) @(posedge clk);
    #1;
    reset = 1'b0;
    #1;
    check("abort_hex", hex_all, z0);
    check("abort_busy", 42'(busy), 42'd0);
    repeat (3) @(posedge clk);
    #1;
    reset = 1'b1;
    expq.push_back(disp(0, 7, 2, 2, 1, 2));
    @(posedge clk); #1;
    check("resample_busy", 42'(busy), 42'd1);
    repeat (35) @(posedge clk);
    #1;

    check("queue_empty", 42'(expq.size()), 42'd0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
